// File: rtl/vga_cursor_overlay.sv
// vga_cursor_overlay: rebuilds pixel x/y from the VGA sync edges and overlays a solid rectangular cursor, one pixclk latency.
// Define CURSOR_BLINK_EN to blink the cursor with a BLINK_FRAMES half-period.
module vga_cursor_overlay #(
    parameter int H_ACTIVE     = 800,
    parameter int V_ACTIVE     = 600,
    parameter int H_AST        = 216,
    parameter int V_AST        = 27,
    parameter int CURSOR_W     = 16,
    parameter int CURSOR_H     = 16,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        pixclk,
    input  logic        reset_pixclk,
    input  logic [4:0]  red_in,
    input  logic [5:0]  green_in,
    input  logic [4:0]  blue_in,
    input  logic        hsync_n_in,
    input  logic        vsync_n_in,
    input  logic        cursor_en,
    input  logic [10:0] cursor_x,
    input  logic [10:0] cursor_y,
    input  logic [15:0] cursor_color,
    output logic [4:0]  red_out,
    output logic [5:0]  green_out,
    output logic [4:0]  blue_out,
    output logic        hsync_n,
    output logic        vsync_n
);
    logic        hs_d, vs_d, hfall, vfall;
    logic [11:0] hcnt, vcnt, hpos, vpos, x, y, cx, cy;
    logic        frame_valid, shadow_en, visible, hit, blink;
    logic [10:0] shadow_x, shadow_y;
    logic [15:0] shadow_color;

    assign hfall   = hs_d & ~hsync_n_in;
    assign vfall   = vs_d & ~vsync_n_in;
    assign hpos    = hfall ? 12'd0 : (&hcnt ? hcnt : hcnt + 12'd1);
    assign vpos    = vfall ? 12'd0 : hfall ? (&vcnt ? vcnt : vcnt + 12'd1) : vcnt;
    assign x       = hpos - 12'(H_AST);
    assign y       = vpos - 12'(V_AST);
    assign cx      = {1'b0, shadow_x};
    assign cy      = {1'b0, shadow_y};
    // bit 11 is the sign of the 12-bit x/y, so negative positions fall out here
    assign visible = !x[11] && x < 12'(H_ACTIVE) && !y[11] && y < 12'(V_ACTIVE);
    assign hit     = frame_valid & shadow_en & blink & visible &
                     (x >= cx) & (x <= cx + 12'(CURSOR_W - 1)) &
                     (y >= cy) & (y <= cy + 12'(CURSOR_H - 1));

`ifdef CURSOR_BLINK_EN
    logic [5:0] blink_cnt;
    // only completed displayed frames count, so the first shown frame opens a full visible half-period
    always_ff @(posedge pixclk) begin
        if (reset_pixclk) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (vfall && frame_valid) begin
            if (blink_cnt == 6'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 6'd1;
            end
        end
    end
`else
    assign blink = 1'b1;
`endif

    always_ff @(posedge pixclk) begin
        if (reset_pixclk) begin
            hs_d         <= 1'b1;
            vs_d         <= 1'b1;
            hcnt         <= '0;
            vcnt         <= '0;
            frame_valid  <= 1'b0;
            shadow_en    <= 1'b0;
            shadow_x     <= '0;
            shadow_y     <= '0;
            shadow_color <= '0;
            {red_out, green_out, blue_out} <= '0;
            hsync_n      <= 1'b1;
            vsync_n      <= 1'b1;
        end else begin
            hs_d <= hsync_n_in;
            vs_d <= vsync_n_in;
            hcnt <= hpos;
            vcnt <= vpos;
            if (vfall) begin
                frame_valid  <= 1'b1;
                shadow_en    <= cursor_en;
                shadow_x     <= cursor_x;
                shadow_y     <= cursor_y;
                shadow_color <= cursor_color;
            end
            {red_out, green_out, blue_out} <= hit ? shadow_color : {red_in, green_in, blue_in};
            hsync_n <= hsync_n_in;
            vsync_n <= vsync_n_in;
        end
    end
endmodule

// File: tb/tb_vga_cursor_overlay.sv
// tb_vga_cursor_overlay: directed bench on a scaled-down sync generator (60x40 total, 40x30 visible).
module tb_vga_cursor_overlay;
    localparam int HL = 60, HS = 8, HAST = 12, HA = 40;
    localparam int VL = 40, VS = 2, VAST = 5, VA = 30;
    localparam int BF = 2;

    logic        clk = 1'b0, rst;
    logic [15:0] rgb_in = 16'h1234;
    logic        hsync_n_in, vsync_n_in, cursor_en;
    logic [10:0] cursor_x, cursor_y;
    logic [15:0] cursor_color;
    logic [4:0]  red_out, blue_out;
    logic [5:0]  green_out;
    logic        hsync_n, vsync_n;

    vga_cursor_overlay #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_AST(HAST), .V_AST(VAST),
        .CURSOR_W(16), .CURSOR_H(16), .BLINK_FRAMES(BF)
    ) dut (
        .pixclk(clk), .reset_pixclk(rst),
        .red_in(rgb_in[15:11]), .green_in(rgb_in[10:5]), .blue_in(rgb_in[4:0]),
        .hsync_n_in(hsync_n_in), .vsync_n_in(vsync_n_in),
        .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .cursor_color(cursor_color),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .hsync_n(hsync_n), .vsync_n(vsync_n)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int seg = 0, exp_seg = 0;
    int hits[6];
    bit have_exp = 0;
    logic [17:0] exp_v;
    bit m_valid = 0, m_en = 0;
    int m_cx = 0, m_cy = 0, m_nf = 0;
    logic [15:0] m_col = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int h, input int v, input bit r);
        int x, y;
        bit hit, bv;
        @(negedge clk);
        if (have_exp) begin
            check($sformatf("pixel seg%0d", exp_seg),
                  {14'd0, hsync_n, vsync_n, red_out, green_out, blue_out}, {14'd0, exp_v});
            if ({red_out, green_out, blue_out} == 16'hF800) hits[exp_seg]++;
        end
        rst        = r;
        hsync_n_in = (h < 0) || (h >= HS);
        vsync_n_in = (h < 0) || (v >= VS);
        if (r) begin
            exp_v   = {2'b11, 16'h0000};
            m_valid = 0;
            m_nf    = 0;
        end else begin
            if (h == 0 && v == 0) begin
                seg++;
                m_valid = 1;
                m_nf++;
                m_en  = cursor_en;
                m_cx  = int'(cursor_x);
                m_cy  = int'(cursor_y);
                m_col = cursor_color;
            end
            x  = h - HAST;
            y  = v - VAST;
`ifdef CURSOR_BLINK_EN
            bv = (((m_nf - 1) / BF) % 2) == 0;
`else
            bv = 1;
`endif
            hit = m_valid && m_en && bv && x >= 0 && x < HA && y >= 0 && y < VA &&
                  x >= m_cx && x <= m_cx + 15 && y >= m_cy && y <= m_cy + 15;
            exp_v = {hsync_n_in, vsync_n_in, hit ? m_col : 16'h1234};
        end
        exp_seg  = seg;
        have_exp = 1;
    endtask

    initial begin
        int h, v;
        int exp_hits[6];
`ifdef CURSOR_BLINK_EN
        exp_hits = '{0, 256, 256, 0, 0, 256};
`else
        exp_hits = '{0, 256, 256, 32, 168, 256};
`endif
        cursor_en    = 1;
        cursor_x     = 11'd10;
        cursor_y     = 11'd5;
        cursor_color = 16'hF800;
        for (int i = 0; i < 4; i++) drive(-1, -1, 1);
        h = 0;
        v = 20;
        while (!(seg == 5 && h == 0 && v == 0)) begin
            if (h == 0 && v == 25) begin
                if (seg == 1) cursor_x = 11'd20;
                if (seg == 2) begin cursor_x = 11'd32; cursor_y = 11'd26; end
                if (seg == 3) begin cursor_x = 11'd10; cursor_y = 11'd5; end
            end
            drive(h, v, seg == 4 && h == 30 && v == 20);
            h++;
            if (h == HL) begin
                h = 0;
                v = (v + 1) % VL;
            end
        end
        drive(-1, -1, 0);
        for (int s = 0; s < 6; s++)
            check($sformatf("cursor_pixels seg%0d", s), 32'(hits[s]), 32'(exp_hits[s]));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
